// File: rtl/crc_defs.sv
// rtl/crc_defs.sv - shared CRC link definitions for the serial CRC generator and checker
package crc_defs;

  // Frame FSM states, shared so both ends of the link decode the same encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_DATA = 2'd1,
    ST_RX_CRC  = 2'd2,
    ST_DONE    = 2'd3
  } crc_state_e;

  localparam int          DEF_DATA_BITS = 48;
  localparam int          DEF_CRC_W     = 16;
  localparam logic [15:0] DEF_POLY      = 16'h1021;
  localparam logic [15:0] DEF_INIT      = 16'hFFFF;

endpackage

// File: rtl/crc_serial_lfsr.sv
// rtl/crc_serial_lfsr.sv - bit-serial non-reflected CRC LFSR, MSB first
module crc_serial_lfsr
  import crc_defs::*;
#(
  parameter int               CRC_W = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0] INIT  = CRC_W'(DEF_INIT)
) (
  input  logic             clock,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  // Preset on init, otherwise advance one step per enabled bit; init wins
  always_ff @(posedge clock) begin
    if (init) begin
      crc <= INIT;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - serial CRC frame receiver/checker with payload recovery
module crc_frame_checker
  import crc_defs::*;
#(
  parameter int               DATA_BITS = DEF_DATA_BITS,
  parameter int               CRC_W     = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0] INIT      = CRC_W'(DEF_INIT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 data,
  input  logic                 data_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic [DATA_BITS-1:0] payload,
  output logic [CRC_W-1:0]     crc_rx,
  output logic [CRC_W-1:0]     crc_calc
);

  localparam int MAX_LEN = (DATA_BITS > CRC_W) ? DATA_BITS : CRC_W;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

  crc_state_e       state;
  crc_state_e       state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] crc_next;
  logic             take_data;
  logic             take_crc;
  logic             data_last;
  logic             crc_last;

  // A start strobe always wins over a coincident data bit, so the bit is dropped
  assign take_data = (state == ST_RX_DATA) && data_valid && !start;
  assign take_crc  = (state == ST_RX_CRC)  && data_valid && !start;
  assign data_last = take_data && (bit_cnt == DATA_LAST);
  assign crc_last  = take_crc  && (bit_cnt == CRC_LAST);
  assign crc_next  = {crc_rx[CRC_W-2:0], data};

  crc_serial_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_lfsr (
    .clock  (clock),
    .init   (start),
    .en     (take_data && !reset),
    .bit_in (data),
    .crc    (lfsr)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: start restarts from any state, otherwise advance on phase-final bits
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = ST_RX_DATA;
    end else begin
      case (state)
        ST_IDLE:    state_n = ST_IDLE;
        ST_RX_DATA: if (data_last) state_n = ST_RX_CRC;
        ST_RX_CRC:  if (crc_last)  state_n = ST_DONE;
        ST_DONE:    state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state: busy through both receive phases, done for the DONE cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RX_DATA: busy = 1'b1;
      ST_RX_CRC:  busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default:    begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Bit counter, payload/check shift registers and result capture on the final check bit
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= '0;
      payload  <= '0;
      crc_rx   <= '0;
      crc_calc <= '0;
      crc_ok   <= 1'b0;
    end else if (start) begin
      bit_cnt  <= '0;
      payload  <= '0;
      crc_rx   <= '0;
      crc_ok   <= 1'b0;
    end else begin
      if (take_data) begin
        payload <= {payload[DATA_BITS-2:0], data};
        bit_cnt <= data_last ? '0 : bit_cnt + CNT_W'(1);
      end
      if (take_crc) begin
        crc_rx  <= crc_next;
        bit_cnt <= crc_last ? '0 : bit_cnt + CNT_W'(1);
        // Results land with the DONE state so done and crc_ok are valid together
        if (crc_last) begin
          crc_calc <= lfsr;
          crc_ok   <= (crc_next == lfsr);
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb/tb_crc_frame_checker.sv - self-checking bench for crc_frame_checker
module tb_crc_frame_checker;

  typedef struct {
    bit          sel72;
    logic [71:0] payload;
    logic [15:0] crc_bits;
    bit          gappy;
    bit          exp_ok;
    logic [15:0] exp_calc;
  } vec_t;

  typedef struct {
    logic [71:0] payload;
    logic [15:0] crc_rx;
    logic [15:0] crc_calc;
    logic        ok;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic data = 1'b0;
  logic data_valid = 1'b0;
  bit   target = 1'b0;

  logic        busy48, done48, ok48;
  logic [47:0] payload48;
  logic [15:0] crc_rx48, crc_calc48;
  logic        busy72, done72, ok72;
  logic [71:0] payload72;
  logic [15:0] crc_rx72, crc_calc72;

  int n_checks = 0;
  int n_fail = 0;
  int dc48 = 0;
  int dc72 = 0;

  exp_t sq[$];
  vec_t vecs[6];

  always #5 clock = ~clock;

  crc_frame_checker dut48 (
    .clock(clock), .reset(reset), .start(start & ~target), .data(data),
    .data_valid(data_valid & ~target), .busy(busy48), .done(done48), .crc_ok(ok48),
    .payload(payload48), .crc_rx(crc_rx48), .crc_calc(crc_calc48)
  );

  crc_frame_checker #(.DATA_BITS(72)) dut72 (
    .clock(clock), .reset(reset), .start(start & target), .data(data),
    .data_valid(data_valid & target), .busy(busy72), .done(done72), .crc_ok(ok72),
    .payload(payload72), .crc_rx(crc_rx72), .crc_calc(crc_calc72)
  );

  always @(posedge clock) begin
    if (done48) dc48++;
    if (done72) dc72++;
  end

  function automatic int cur_done();
    return target ? dc72 : dc48;
  endfunction

  function automatic logic [15:0] crc_model(input logic [71:0] p, input int n);
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = r[15] ^ p[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [71:0] val, input int n, input bit gappy);
    for (int i = n - 1; i >= 0; i--) begin
      if (gappy) begin
        data_valid = 1'b0;
        data = ~val[i];
        tick();
      end
      data = val[i];
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    data = 1'b0;
  endtask

  task automatic finish_frame(input int d0);
    exp_t e;
    int waited;
    logic        d_sel, ok_sel;
    logic [71:0] p_sel;
    logic [15:0] rx_sel, calc_sel;
    waited = 0;
    @(negedge clock);
    chk("done_latency", 72'(target ? done72 : done48), 72'(1));
    while (!(target ? done72 : done48) && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    d_sel = target ? done72 : done48;
    if (!d_sel) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 8 cycles");
    end
    p_sel    = target ? payload72 : {24'h0, payload48};
    rx_sel   = target ? crc_rx72 : crc_rx48;
    calc_sel = target ? crc_calc72 : crc_calc48;
    ok_sel   = target ? ok72 : ok48;
    e = sq.pop_front();
    chk("payload", p_sel, e.payload);
    chk("crc_rx", 72'(rx_sel), 72'(e.crc_rx));
    chk("crc_calc", 72'(calc_sel), 72'(e.crc_calc));
    chk("crc_ok", 72'(ok_sel), 72'(e.ok));
    tick();
    chk("done_count", 72'(cur_done() - d0), 72'(1));
  endtask

  task automatic run_frame(input vec_t v);
    int d0;
    target = v.sel72;
    sq.push_back('{v.payload, v.crc_bits, v.exp_calc, v.exp_ok});
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = cur_done();
    send_bits(v.payload, v.sel72 ? 72 : 48, v.gappy);
    send_bits({56'h0, v.crc_bits}, 16, v.gappy);
    finish_frame(d0);
  endtask

  initial begin
    logic [63:0] rnd64;
    logic [47:0] p3, p4, p6, p7;
    logic [15:0] c;
    int d0;

    p3 = 48'h03010203303A;
    rnd64 = {$urandom, $urandom};
    p4 = rnd64[47:0];
    vecs[0] = '{1'b1, 72'h313233343536373839, 16'h29B1, 1'b0, 1'b1, 16'h29B1};
    vecs[1] = '{1'b1, 72'h313233343536373839, 16'h29B0, 1'b0, 1'b0, 16'h29B1};
    c = crc_model({24'h0, p3}, 48);
    vecs[2] = '{1'b0, {24'h0, p3}, c, 1'b1, 1'b1, c};
    c = crc_model({24'h0, p4}, 48);
    vecs[3] = '{1'b0, {24'h0, p4}, c ^ 16'h0100, 1'b0, 1'b0, c};
    c = crc_model(72'h0, 48);
    vecs[4] = '{1'b0, 72'h0, c, 1'b0, 1'b1, c};
    c = crc_model({24'h0, 48'hFFFFFFFFFFFF}, 48);
    vecs[5] = '{1'b0, {24'h0, 48'hFFFFFFFFFFFF}, c, 1'b1, 1'b1, c};

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    chk("reset48", {busy48, done48, ok48, payload48, crc_rx48}, 72'h0);
    chk("reset48_calc", 72'(crc_calc48), 72'h0);
    chk("reset72", {busy72, done72, ok72, crc_rx72, crc_calc72}, 72'h0);
    chk("reset72_payload", payload72, 72'h0);
    reset = 1'b0;
    tick();

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      if (i == 0) begin
        repeat (3) tick();
        chk("crc_ok_held", 72'(ok72), 72'(1));
      end
    end

    // Abort: 20 bits then restart with a full valid frame
    target = 1'b0;
    d0 = dc48;
    start = 1'b1;
    tick();
    start = 1'b0;
    rnd64 = {$urandom, $urandom};
    send_bits({8'h0, rnd64}, 20, 1'b0);
    p6 = 48'hA5C3_0F1E_2D3C;
    c = crc_model({24'h0, p6}, 48);
    run_frame('{1'b0, {24'h0, p6}, c, 1'b0, 1'b1, c});
    chk("abort_single_done", 72'(dc48 - d0), 72'(1));

    // Reset mid-frame after 30 bits
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = dc48;
    send_bits({24'h0, p6}, 30, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("midreset_outs", {busy48, done48, ok48, payload48, crc_rx48}, 72'h0);
    chk("midreset_calc", 72'(crc_calc48), 72'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("midreset_no_done", 72'(dc48 - d0), 72'(0));
    p7 = 48'h1234_8765_ABCD;
    c = crc_model({24'h0, p7}, 48);
    run_frame('{1'b0, {24'h0, p7}, c, 1'b1, 1'b1, c});

    // start with a coincident valid bit: that bit is discarded
    target = 1'b0;
    p6 = 48'h5A5A_1234_5678;
    c = crc_model({24'h0, p6}, 48);
    sq.push_back('{{24'h0, p6}, c, c, 1'b1});
    start = 1'b1;
    data = 1'b1;
    data_valid = 1'b1;
    @(negedge clock);
    chk("busy_before_start", 72'(busy48), 72'(0));
    tick();
    start = 1'b0;
    data_valid = 1'b0;
    data = 1'b0;
    @(negedge clock);
    chk("busy_after_start", 72'(busy48), 72'(1));
    d0 = dc48;
    send_bits({24'h0, p6}, 48, 1'b0);
    send_bits({56'h0, c}, 16, 1'b0);
    finish_frame(d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
